// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Instruction fetch buffer sitting directly behind the program counter.
//   While fetching it requests the word at the current pc, and each word the
//   memory returns is stored in a small FIFO together with its address. The
//   same cycle it pulses pc_cnt so the counter moves to the next address.
//   Decode drains the FIFO through a valid/ready handshake. A jump (flush)
//   discards everything buffered or arriving and restarts fetching from the
//   new pc after one settle cycle.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   pc        current program counter value (fetch address)
//   pc_cnt    increment request to the program counter
//   flush     pc is being loaded with a jump target this cycle
//   mem_req   instruction memory read request
//   mem_addr  read address (combinational copy of pc)
//   mem_ack   read data valid this cycle
//   mem_data  read data
//   ir_valid  head entry available to decode
//   ir_ready  decode accepts the head entry
//   ir_data   head instruction word
//   ir_addr   address the head word was fetched from
//   count     FIFO occupancy, 0..DEPTH
module fetch_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         pc,
  output logic                     pc_cnt,
  input  logic                     flush,
  output logic                     mem_req,
  output logic [WIDTH-1:0]         mem_addr,
  input  logic                     mem_ack,
  input  logic [WIDTH-1:0]         mem_data,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  output logic [WIDTH-1:0]         ir_data,
  output logic [WIDTH-1:0]         ir_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] ir_data_q, ir_data_d;
  logic [WIDTH-1:0] ir_addr_q, ir_addr_d;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [WIDTH-1:0] addr_mem [DEPTH];

  logic push;
  logic pop;

  // A word is accepted only while fetching with room left; a jump in the
  // same cycle throws the returning word away.
  assign push = (state_q == ST_FETCH) & mem_ack & ~flush & (count_q < DEPTH_C);
  // Flush wins over a simultaneous pop.
  assign pop  = (count_q != '0) & ir_ready & ~flush;

  assign pc_cnt   = push;
  assign mem_req  = (state_q == ST_FETCH);
  assign mem_addr = pc;
  assign ir_valid = (count_q != '0);
  assign ir_data  = ir_data_q;
  assign ir_addr  = ir_addr_q;
  assign count    = count_q;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ir_data_d = ir_data_q;
    ir_addr_d = ir_addr_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      // The head is kept in registers so it holds its last value once the
      // FIFO runs dry. When the word being pushed lands in the new head
      // slot (empty FIFO, or the only entry is popped) it is forwarded.
      if (count_d != '0) begin
        if (push && (wr_ptr_q == rd_ptr_d)) begin
          ir_data_d = mem_data;
          ir_addr_d = pc;
        end else begin
          ir_data_d = data_mem[rd_ptr_d];
          ir_addr_d = addr_mem[rd_ptr_d];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_FETCH;
        ST_FETCH: if (push && !pop && (count_q == DEPTH_C - 1'b1)) state_d = ST_FULL;
        ST_FULL:  if (pop) state_d = ST_FETCH;
        ST_FLUSH: state_d = ST_FETCH;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ir_data_q <= '0;
      ir_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ir_data_q <= ir_data_d;
      ir_addr_q <= ir_addr_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mem_data;
      addr_mem[wr_ptr_q] <= pc;
    end
  end

endmodule
